// File: rtl/board_port_arbiter_pkg.sv
// Shared board geometry, cell width and arbiter state encoding.
// Every board_port_arbiter file imports this package.
// Holds no logic, only types and constants.
package board_pkg;

  localparam int BOARD_W = 32;
  localparam int BOARD_H = 16;
  localparam int X_W     = 5;
  localparam int Y_W     = 4;
  localparam int CELL_W  = 4;

  // Coordinates of the final raster cell.
  localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/board_port_arbiter_if.sv
// Bundles the game, EPP loader and RAM port B signals of the board arbiter.
// The slave modport is the arbiter side; master is the game/loader/RAM side.
// The clear_start/clear_busy pair exists only when BOARD_CLEAR_EN is defined.
interface board_port_arbiter_if;
  import board_pkg::*;

  logic              game_req;
  logic              game_we;
  logic [X_W-1:0]    game_x;
  logic [Y_W-1:0]    game_y;
  logic [CELL_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [CELL_W-1:0] game_rdata;
  logic              epp_wr;
  logic [CELL_W-1:0] epp_data;
  logic              epp_overflow;
  logic              load_done;
  logic [X_W-1:0]    ram_x;
  logic [Y_W-1:0]    ram_y;
  logic              ram_rd;
  logic              ram_wr;
  logic [CELL_W-1:0] ram_in;
  logic [CELL_W-1:0] ram_out;

`ifdef BOARD_CLEAR_EN
  logic              clear_start;
  logic              clear_busy;

  modport slave (
    input  game_req, game_we, game_x, game_y, game_wdata, epp_wr, epp_data, ram_out, clear_start,
    output game_gnt, game_rvalid, game_rdata, epp_overflow, load_done,
           ram_x, ram_y, ram_rd, ram_wr, ram_in, clear_busy
  );
  modport master (
    output game_req, game_we, game_x, game_y, game_wdata, epp_wr, epp_data, ram_out, clear_start,
    input  game_gnt, game_rvalid, game_rdata, epp_overflow, load_done,
           ram_x, ram_y, ram_rd, ram_wr, ram_in, clear_busy
  );
`else
  modport slave (
    input  game_req, game_we, game_x, game_y, game_wdata, epp_wr, epp_data, ram_out,
    output game_gnt, game_rvalid, game_rdata, epp_overflow, load_done,
           ram_x, ram_y, ram_rd, ram_wr, ram_in
  );
  modport master (
    output game_req, game_we, game_x, game_y, game_wdata, epp_wr, epp_data, ram_out,
    input  game_gnt, game_rvalid, game_rdata, epp_overflow, load_done,
           ram_x, ram_y, ram_rd, ram_wr, ram_in
  );
`endif

endinterface

// File: rtl/board_load_fifo.sv
// Purpose: small synchronous FIFO buffering host nibbles for the board loader.
// Latency: a pushed nibble is visible at head the cycle after the push.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and sets a sticky overflow.
module board_load_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_port_arbiter.sv
// Purpose: shares RAM port B of the snake board between game accesses and the EPP raster loader (BOARD_CLEAR_EN adds a clearing sweep).
// Latency: grant combinational in cycle N, RAM strobe registered at N+1, game read data at N+2.
// Backpressure: game holds req until gnt; loader wins while buffered, except the game wins after MAX_BURST loader grants.
module board_port_arbiter
  import board_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  board_port_arbiter_if.slave bus
);

  localparam int              BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              load_sel;
  logic              game_sel;
  logic              clr_wr;
`ifdef BOARD_CLEAR_EN
  logic              clear_go;
`endif
  logic [BW-1:0]     burst_q;
  logic [X_W-1:0]    lx;
  logic [Y_W-1:0]    ly;
  logic              at_last;
  logic [CELL_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic [X_W-1:0]    acc_x;
  logic [Y_W-1:0]    acc_y;
  logic [CELL_W-1:0] acc_d;
  logic              rvalid_q;

  board_load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CELL_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.epp_wr),
    .din      (bus.epp_data),
    .pop      (load_sel),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  assign at_last = (lx == X_LAST) && (ly == Y_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-cycle source selection and next state; at most one source wins.
  always_comb begin
    state_d  = state_q;
    load_sel = 1'b0;
    game_sel = 1'b0;
    clr_wr   = 1'b0;
`ifdef BOARD_CLEAR_EN
    clear_go = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        load_sel = !fifo_empty && !(bus.game_req && (burst_q == BURST_MAX));
        game_sel = bus.game_req && !load_sel;
`ifdef BOARD_CLEAR_EN
        clear_go = bus.clear_start;
        if (bus.clear_start) begin
          state_d = CLEAR;
        end
`endif
      end
`ifdef BOARD_CLEAR_EN
      CLEAR: begin
        clr_wr = 1'b1;
        if (at_last) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address/data of the winning access, zero when nothing is granted.
  always_comb begin
    acc_x = '0;
    acc_y = '0;
    acc_d = '0;
    if (load_sel) begin
      acc_x = lx;
      acc_y = ly;
      acc_d = fifo_head;
    end else if (clr_wr) begin
      acc_x = lx;
      acc_y = ly;
    end else if (game_sel) begin
      acc_x = bus.game_x;
      acc_y = bus.game_y;
      acc_d = bus.game_we ? bus.game_wdata : '0;
    end
  end

  // Consecutive loader grants seen while the game waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else if (!bus.game_req || game_sel) begin
      burst_q <= '0;
    end else if (load_sel && (burst_q != BURST_MAX)) begin
      burst_q <= burst_q + 1'b1;
    end
  end

  // Raster pointer shared by loader fill and clearing sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      lx <= '0;
      ly <= '0;
    end
`ifdef BOARD_CLEAR_EN
    else if (clear_go) begin
      lx <= '0;
      ly <= '0;
    end
`endif
    else if (load_sel || clr_wr) begin
      if (lx == X_LAST) begin
        lx <= '0;
        ly <= (ly == Y_LAST) ? '0 : ly + 1'b1;
      end else begin
        lx <= lx + 1'b1;
      end
    end
  end

  // Register the chosen access onto port B for one cycle; read data returns one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ram_x     <= '0;
      bus.ram_y     <= '0;
      bus.ram_in    <= '0;
      bus.ram_rd    <= 1'b0;
      bus.ram_wr    <= 1'b0;
      bus.load_done <= 1'b0;
      rvalid_q      <= 1'b0;
    end else begin
      bus.ram_x     <= acc_x;
      bus.ram_y     <= acc_y;
      bus.ram_in    <= acc_d;
      bus.ram_rd    <= game_sel && !bus.game_we;
      bus.ram_wr    <= load_sel || clr_wr || (game_sel && bus.game_we);
      bus.load_done <= load_sel && at_last;
      rvalid_q      <= bus.ram_rd;
    end
  end

  assign bus.game_gnt     = game_sel;
  assign bus.game_rvalid  = rvalid_q;
  assign bus.game_rdata   = rvalid_q ? bus.ram_out : '0;
  assign bus.epp_overflow = fifo_overflow;
`ifdef BOARD_CLEAR_EN
  assign bus.clear_busy   = (state_q == CLEAR);
`endif

endmodule

// File: tb/tb_board_port_arbiter.sv
// Scoreboard bench for board_port_arbiter: stimulus queues expected RAM strobes
// and read responses, a negedge monitor pops and compares them.
module tb_board_port_arbiter;
  import board_pkg::*;

  typedef struct {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [CELL_W-1:0] d;
    logic              done;
  } wr_exp_t;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    int             cyc;
    int             gap;
    bit             chk_gap;
  } rd_exp_t;

  typedef struct {
    logic [CELL_W-1:0] d;
    int                cyc;
  } rv_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_port_arbiter_if bif();

  board_port_arbiter #(
    .FIFO_DEPTH (2),
    .MAX_BURST  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Behavioural RAM port B: write on strobe, read data one cycle after ram_rd.
  logic [CELL_W-1:0] mem [BOARD_W*BOARD_H];
  always @(posedge clk) begin
    if (bif.ram_wr) mem[{bif.ram_y, bif.ram_x}] <= bif.ram_in;
    if (bif.ram_rd) bif.ram_out <= mem[{bif.ram_y, bif.ram_x}];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  rv_exp_t rv_q[$];
  bit chk_wr = 1'b1;
  int wr_since_rd = 0;
  logic [X_W-1:0] exp_lx = '0;
  logic [Y_W-1:0] exp_ly = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a strobe or a read response.
  always @(negedge clk) begin
    if (rst) begin
      wr_since_rd = 0;
    end else begin
      if (bif.ram_rd) begin
        if (rd_q.size() == 0) begin
          check("unexpected_ram_rd", 1, 0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_addr", {bif.ram_x, bif.ram_y}, {e.x, e.y});
          check("rd_cycle", cyc, e.cyc);
          if (e.chk_gap) check("loader_writes_between_game_grants", wr_since_rd, e.gap);
        end
        wr_since_rd = 0;
      end
      if (bif.ram_wr) begin
        wr_since_rd++;
        if (chk_wr) begin
          if (wr_q.size() == 0) begin
            check("unexpected_ram_wr", 1, 0);
          end else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            check("wr_x_y_data_done", {bif.ram_x, bif.ram_y, bif.ram_in, bif.load_done},
                  {w.x, w.y, w.d, w.done});
          end
        end
      end else if (bif.load_done) begin
        check("load_done_without_wr", 1, 0);
      end
      if (bif.game_rvalid) begin
        if (rv_q.size() == 0) begin
          check("unexpected_rvalid", 1, 0);
        end else begin
          rv_exp_t r;
          r = rv_q.pop_front();
          check("rdata", bif.game_rdata, r.d);
          check("rvalid_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_lx = '0;
    exp_ly = '0;
  endtask

  task automatic adv_ptr();
    if (exp_lx == X_LAST) begin
      exp_lx = '0;
      exp_ly = (exp_ly == Y_LAST) ? '0 : exp_ly + 1'b1;
    end else begin
      exp_lx = exp_lx + 1'b1;
    end
  endtask

  // One loader nibble, two cycles apart; expected write goes to the raster pointer.
  task automatic push_nibble(input logic [CELL_W-1:0] d);
    if (chk_wr) wr_q.push_back('{x: exp_lx, y: exp_ly, d: d, done: (exp_lx == X_LAST && exp_ly == Y_LAST)});
    adv_ptr();
    bif.epp_wr = 1'b1;
    bif.epp_data = d;
    tick();
    bif.epp_wr = 1'b0;
    tick();
  endtask

  // Game access; d is write data or hand-computed read data. lat = cycles until gnt.
  task automatic game_op(input bit we, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                         input logic [CELL_W-1:0] d, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    bif.game_req = 1'b1;
    bif.game_we = we;
    bif.game_x = x;
    bif.game_y = y;
    bif.game_wdata = we ? d : '0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bif.game_gnt) begin
        got = 1'b1;
        lat = i;
        if (we) wr_q.push_back('{x: x, y: y, d: d, done: 1'b0});
        else begin
          rd_q.push_back('{x: x, y: y, cyc: cyc + 1, gap: 0, chk_gap: 1'b0});
          rv_q.push_back('{d: d, cyc: cyc + 2});
        end
      end
      tick();
    end
    bif.game_req = 1'b0;
    check("game_gnt_within_budget", got, 1);
  endtask

  initial begin
    int lat;
    logic ovf_ok;
    bif.game_req = 0; bif.game_we = 0; bif.game_x = '0; bif.game_y = '0; bif.game_wdata = '0;
    bif.epp_wr = 0; bif.epp_data = '0;
`ifdef BOARD_CLEAR_EN
    bif.clear_start = 0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {bif.game_gnt, bif.game_rvalid, bif.game_rdata, bif.epp_overflow, bif.load_done,
           bif.ram_x, bif.ram_y, bif.ram_rd, bif.ram_wr, bif.ram_in}, 0);
    tick();

    // Game writes then reads back; first read must be granted in its own cycle.
    game_op(1'b1, 5'd3, 4'd5, 4'hA, lat);
    game_op(1'b1, 5'd31, 4'd15, 4'h7, lat);
    game_op(1'b0, 5'd3, 4'd5, 4'hA, lat);
    check("read_gnt_same_cycle", lat, 0);
    game_op(1'b0, 5'd31, 4'd15, 4'h7, lat);
    repeat (4) tick();

    // Continuous nibbles with the game waiting: game wins after every 4 loader grants.
    do_reset();
    chk_wr = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bit exp_g;
      bif.epp_wr = 1'b1;
      bif.epp_data = 4'(c);
      bif.game_req = (c >= 2);
      bif.game_we = 1'b0;
      bif.game_x = 5'd31;
      bif.game_y = 4'd15;
      @(negedge clk);
      exp_g = (c == 6) || (c == 11) || (c == 16) || (c == 21);
      check($sformatf("burst_gnt_c%0d", c), bif.game_gnt, exp_g);
      if (bif.game_gnt) begin
        rd_q.push_back('{x: 5'd31, y: 4'd15, cyc: cyc + 1, gap: 4, chk_gap: (c != 6)});
        rv_q.push_back('{d: 4'h7, cyc: cyc + 2});
      end
      if (c == 11) check("overflow_before_drop", bif.epp_overflow, 0);
      if (c == 12) check("overflow_after_drop", bif.epp_overflow, 1);
      tick();
    end
    bif.epp_wr = 1'b0;
    bif.game_req = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("overflow_sticky", bif.epp_overflow, 1);
    tick();

    // Full raster load from reset.
    do_reset();
    @(negedge clk);
    check("overflow_cleared_by_rst", bif.epp_overflow, 0);
    tick();
    chk_wr = 1'b1;
    for (int i = 0; i < BOARD_W*BOARD_H; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      push_nibble(iv[3:0] ^ iv[7:4]);
    end
    repeat (3) tick();
    @(negedge clk);
    check("overflow_after_full_load", bif.epp_overflow, 0);
    tick();

    // Reset one cycle after a read grant with a nibble still queued.
    push_nibble(4'h1);
    push_nibble(4'h2);
    push_nibble(4'h3);
    repeat (2) tick();
    bif.game_req = 1'b1; bif.game_we = 1'b0; bif.game_x = 5'd3; bif.game_y = 4'd5;
    bif.epp_wr = 1'b1; bif.epp_data = 4'hE;
    @(negedge clk);
    check("rst_test_gnt", bif.game_gnt, 1);
    tick();
    bif.game_req = 1'b0; bif.epp_wr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_lx = '0;
    exp_ly = '0;
    ovf_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ovf_ok = ovf_ok | bif.game_rvalid;
      tick();
    end
    check("no_rvalid_after_rst", ovf_ok, 0);
    push_nibble(4'h5);
    repeat (3) tick();

`ifdef BOARD_CLEAR_EN
    begin
      int busy;
      bit gnt_seen;
      busy = 0;
      gnt_seen = 1'b0;
      for (int i = 0; i < BOARD_W*BOARD_H; i++) begin
        logic [8:0] iv;
        iv = 9'(i);
        wr_q.push_back('{x: iv[4:0], y: iv[8:5], d: 4'h0, done: 1'b0});
      end
      for (int i = 0; i < 700; i++) begin
        bif.clear_start = (i == 0) || (i == 200);
        bif.game_req = (i >= 1) && (i <= 100);
        bif.game_we = 1'b0;
        @(negedge clk);
        if (bif.clear_busy) busy++;
        if (bif.game_gnt) gnt_seen = 1'b1;
        tick();
        if (i > 5 && !bif.clear_busy) break;
      end
      bif.clear_start = 1'b0;
      bif.game_req = 1'b0;
      check("clear_busy_cycles", busy, BOARD_W*BOARD_H);
      check("gnt_during_clear", gnt_seen, 0);
      exp_lx = '0;
      exp_ly = '0;
      repeat (3) tick();
      push_nibble(4'h9);
      repeat (3) tick();
    end
`endif

    for (int i = 0; i < 100 && (wr_q.size() + rd_q.size() + rv_q.size()) != 0; i++) tick();
    check("pending_expectations", wr_q.size() + rd_q.size() + rv_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
